traffic_signal_multi: RTL and testbench
=======================================

Name: traffic_signal_multi

Overview:
Parametrised N-way intersection controller and next generation of the team's single-approach traffic signal FSM. Serves approaches in round-robin order with a GREEN -> YELLOW -> ALL-RED sequence. Per-phase durations are counted in external time-base ticks, and approaches with no waiting vehicles are skipped. Sits between the vehicle-sensor front end and the lamp drivers.

Parameters:
N_WAYS, 4, number of approaches (2..16)
CNT_W, 8, phase timer width in bits
GREEN_TICKS, 20, green duration in ticks (1..2^CNT_W-1)
YELLOW_TICKS, 4, yellow duration in ticks (1..2^CNT_W-1)
ALLRED_TICKS, 2, all-red clearance in ticks (1..2^CNT_W-1)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
tick_en  in  1  one-cycle time-base strobe; timers advance only on this
demand  in  N_WAYS  bit i high = vehicle waiting on approach i
hold  in  1  freezes the phase timer while high; state and lights unchanged
light  out  3*N_WAYS  per-approach lamp; slice [3i+2:3i] = {R,G,Y}; RED=3'b100, GREEN=3'b010, YELLOW=3'b001
active_way  out  $clog2(N_WAYS)  index of the approach currently owning the right of way
phase  out  2  0=ALLRED, 1=GREEN, 2=YELLOW

Behaviour:
- Reset (sync, rst=1 at posedge):
  - phase=ALLRED, active_way=N_WAYS-1, timer=ALLRED_TICKS-1.
  - All light slices = RED.
  - rst has priority over every other input, including mid-phase.
- Phase timer:
  - On phase entry, load DUR-1.
  - Each cycle with tick_en=1 and hold=0: if timer==0 the phase ends, otherwise decrement.
  - Each phase therefore lasts exactly DUR ticks.
  - tick_en while hold=1 is dropped, not queued.
- Transitions (all take effect at the posedge where the phase ends):
  - GREEN -> YELLOW, same way.
  - YELLOW -> ALLRED, same way.
  - ALLRED -> GREEN on way `next`.
- Selecting `next` (computed from demand sampled at the ALLRED-ending edge):
  - First index with demand set, searching cyclically from active_way+1 and wrapping N_WAYS-1 -> 0.
  - The search includes active_way itself, last.
  - If no demand bit is set, next = active_way+1 (mod N_WAYS), giving a fixed cycle.
- Lights:
  - Registered; they change on the same edge as phase/active_way.
  - Slice active_way shows GREEN or YELLOW per phase. Every other slice, and all slices in ALLRED, show RED.
  - Exactly one slice is non-RED outside ALLRED. Two non-RED slices is a fatal assertion.
- Illegal phase encoding (3): forced next cycle to ALLRED, timer=ALLRED_TICKS-1, active_way unchanged.
- Demand changes mid-GREEN have no effect on the current green; there is no early termination.
- Boundary case DUR=1: the phase lasts exactly one tick.
- Boundary case N_WAYS=2: the controller alternates 0/1 whenever both approaches have demand, or none does.

Optional Feature:
Macro EMERGENCY_PREEMPT_EN.
- Defined: adds ports preempt (in, 1) and preempt_way (in, $clog2(N_WAYS)).
  - While preempt=1 and the controller is in GREEN on a way other than preempt_way, it enters YELLOW at the next edge (timer reloads YELLOW_TICKS-1), then ALLRED as normal.
  - The following GREEN goes to preempt_way regardless of demand.
  - In GREEN on preempt_way the timer is frozen while preempt=1.
  - Normal sequencing resumes once preempt falls.
  - hold does not override preempt.
- Undefined: ports absent; behaviour exactly as above.

Decomposition:
- Package traffic_pkg holds:
  - light encodings RED/GREEN/YELLOW as 3-bit localparams;
  - phase enum PH_ALLRED=0, PH_GREEN=1, PH_YELLOW=2;
  - a function computing the cyclic next-demand index.
- Sub-module phase_timer (CNT_W-bit loadable down-counter with tick_en/hold, `load` and `expired` outputs) is instantiated once.
- The FSM and light decode stay in traffic_signal_multi.

Test Plan:
1. rst=1 for 3 cycles, tick_en=1 continuous -> all lights RED, phase=0, active_way=3. After release: 2 ticks ALLRED, then light slice 0 = GREEN.
2. demand=4'b1111, tick_en every cycle -> sequence per way is 20 GREEN, 4 YELLOW, 2 ALLRED cycles. Ways served 0,1,2,3,0.
3. demand=4'b0100 from reset -> only way 2 ever goes GREEN. Way 2 repeats GREEN after each ALLRED; other slices stay RED.
4. demand=0 -> fixed cycle 0,1,2,3. Setting demand=4'b1000 during way-0 GREEN -> next green is way 3, skipping 1 and 2.
5. hold=1 for 10 ticks mid-GREEN -> timer frozen, so GREEN lasts 30 ticks. Asserting rst mid-YELLOW -> ALLRED, active_way=3 on the next edge.
6. (EMERGENCY_PREEMPT_EN) preempt=1, preempt_way=2 during way-0 GREEN -> YELLOW next edge, ALLRED, then way-2 GREEN held until preempt=0, then 20 more ticks.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase enum and the cyclic demand search
// used by the multi-way traffic signal controller.
package traffic_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;

  localparam int MAX_WAYS = 16;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_e;

  // First waiting way after cur, wrapping, cur itself last;
  // falls back to cur+1 when nobody waits.
  function automatic logic [3:0] next_demand_idx(
    input logic [MAX_WAYS-1:0] dem,
    input logic [3:0]          cur,
    input int                  n
  );
    logic [3:0] res;
    logic       found;
    int         idx;
    idx   = (int'(cur) + 1) % n;
    res   = idx[3:0];
    found = 1'b0;
    for (int k = 1; k <= MAX_WAYS; k++) begin
      if (k <= n && !found) begin
        idx = (int'(cur) + k) % n;
        if (dem[idx[3:0]]) begin
          res   = idx[3:0];
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/traffic_signal_multi_timer.sv
// Loadable phase down-counter advanced by the time-base strobe.
// expired flags the tick that finds the count already at zero.
module phase_timer #(
  parameter int               CNT_W = 8,
  parameter logic [CNT_W-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             hold,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;
  logic             adv;

  assign adv     = tick_en & ~hold;
  assign expired = adv & (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= INIT;
    end else if (load) begin
      cnt <= load_val;
    end else if (adv && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/traffic_signal_multi.sv
// N-way round-robin signal controller, demand-skipping.
// Optional emergency preemption under EMERGENCY_PREEMPT_EN.
module traffic_signal_multi
  import traffic_pkg::*;
#(
  parameter int N_WAYS       = 4,
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_en,
  input  logic [N_WAYS-1:0]         demand,
  input  logic                      hold,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic                      preempt,
  input  logic [$clog2(N_WAYS)-1:0] preempt_way,
`endif
  output logic [3*N_WAYS-1:0]       light,
  output logic [$clog2(N_WAYS)-1:0] active_way,
  output logic [1:0]                phase
);

  localparam int WAY_W = $clog2(N_WAYS);
  localparam logic [CNT_W-1:0] G_LD = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] A_LD = CNT_W'(ALLRED_TICKS - 1);

  logic [1:0]          phase_q, phase_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [WAY_W-1:0]    next_idx;
  logic [3*N_WAYS-1:0] light_q, light_d;
  logic [N_WAYS-1:0]   nonred;
  logic                load;
  logic [CNT_W-1:0]    load_val;
  logic                expired;
  logic                hold_eff;
  logic                pre_on;
  logic                pre_yel;
  logic                pre_frz;
  logic [WAY_W-1:0]    pre_way;

`ifdef EMERGENCY_PREEMPT_EN
  assign pre_on  = preempt;
  assign pre_way = preempt_way;
`else
  assign pre_on  = 1'b0;
  assign pre_way = '0;
`endif

  // Preempted green on another way is cut short; on the
  // preempt way it is held for as long as preempt stays up.
  assign pre_yel = pre_on && phase_q == PH_GREEN
                && way_q != pre_way;
  assign pre_frz = pre_on && phase_q == PH_GREEN
                && way_q == pre_way;
  assign hold_eff = hold | pre_frz;

  assign next_idx = WAY_W'(next_demand_idx(
    MAX_WAYS'(demand), 4'(way_q), N_WAYS));

  phase_timer #(
    .CNT_W (CNT_W),
    .INIT  (A_LD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick_en  (tick_en),
    .hold     (hold_eff),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_ALLRED;
      way_q   <= WAY_W'(N_WAYS - 1);
      light_q <= {N_WAYS{RED}};
    end else begin
      phase_q <= phase_d;
      way_q   <= way_d;
      light_q <= light_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    way_d    = way_q;
    load     = 1'b0;
    load_val = A_LD;
    unique case (phase_q)
      PH_GREEN: begin
        if (pre_yel || expired) begin
          phase_d  = PH_YELLOW;
          load     = 1'b1;
          load_val = Y_LD;
        end
      end
      PH_YELLOW: begin
        if (expired) begin
          phase_d  = PH_ALLRED;
          load     = 1'b1;
          load_val = A_LD;
        end
      end
      PH_ALLRED: begin
        if (expired) begin
          phase_d  = PH_GREEN;
          way_d    = pre_on ? pre_way : next_idx;
          load     = 1'b1;
          load_val = G_LD;
        end
      end
      default: begin
        phase_d  = PH_ALLRED;
        load     = 1'b1;
        load_val = A_LD;
      end
    endcase
  end

  // Lamps are decoded from the next state so they register
  // on the same edge as phase and active_way.
  always_comb begin
    light_d = {N_WAYS{RED}};
    for (int i = 0; i < N_WAYS; i++) begin
      if (way_d == WAY_W'(i)) begin
        if (phase_d == PH_GREEN) begin
          light_d[3*i +: 3] = GREEN;
        end else if (phase_d == PH_YELLOW) begin
          light_d[3*i +: 3] = YELLOW;
        end
      end
    end
  end

  always_comb begin
    nonred = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      nonred[i] = light_q[3*i +: 3] != RED;
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    $onehot0(nonred))
    else $fatal(1, "two approaches not red");

  assert property (@(posedge clk) disable iff (rst)
    (phase_q != PH_ALLRED) |-> $onehot(nonred))
    else $fatal(1, "no lit approach outside all-red");

  assign light      = light_q;
  assign active_way = way_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_signal_multi.sv
// Self-checking bench for traffic_signal_multi: tick-count model
// compared every cycle plus directed literal expectations.
module tb_traffic_signal_multi;

  localparam int NW  = 4;
  localparam int GD  = 20;
  localparam int YD  = 4;
  localparam int AD  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            tick_en;
  logic [NW-1:0]   demand;
  logic            hold;
  logic [3*NW-1:0] light;
  logic [1:0]      active_way;
  logic [1:0]      phase;
`ifdef EMERGENCY_PREEMPT_EN
  logic            preempt = 1'b0;
  logic [1:0]      preempt_way = 2'd0;
`endif

  traffic_signal_multi dut (
    .clk         (clk),
    .rst         (rst),
    .tick_en     (tick_en),
    .demand      (demand),
    .hold        (hold),
`ifdef EMERGENCY_PREEMPT_EN
    .preempt     (preempt),
    .preempt_way (preempt_way),
`endif
    .light       (light),
    .active_way  (active_way),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic started = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: phase number, owning way, ticks spent in phase.
  typedef struct packed {
    int ph;
    int way;
    int done;
  } mstate_t;

  mstate_t ms = '{ph: 0, way: NW-1, done: 0};

  function automatic int dur(input int ph);
    if (ph == 1) return GD;
    if (ph == 2) return YD;
    return AD;
  endfunction

  function automatic int pick(input int cur, input logic [NW-1:0] d);
    for (int k = 1; k <= NW; k++) begin
      if (d[(cur + k) % NW]) return (cur + k) % NW;
    end
    return (cur + 1) % NW;
  endfunction

  function automatic mstate_t model_next(input mstate_t s,
                                         input logic r,
                                         input logic t,
                                         input logic h,
                                         input logic [NW-1:0] d);
    mstate_t n;
    n = s;
    if (r) begin
      n.ph = 0; n.way = NW-1; n.done = 0;
    end else if (t && !h) begin
      n.done = s.done + 1;
      if (n.done >= dur(s.ph)) begin
        n.done = 0;
        if (s.ph == 1) n.ph = 2;
        else if (s.ph == 2) n.ph = 0;
        else begin
          n.ph = 1;
          n.way = pick(s.way, d);
        end
      end
    end
    return n;
  endfunction

  function automatic logic [3*NW-1:0] exp_light(input mstate_t s);
    logic [3*NW-1:0] l;
    for (int i = 0; i < NW; i++) begin
      l[3*i +: 3] = 3'b100;
      if (s.ph != 0 && i == s.way)
        l[3*i +: 3] = (s.ph == 1) ? 3'b010 : 3'b001;
    end
    return l;
  endfunction

  always @(posedge clk)
    ms <= model_next(ms, rst, tick_en, hold, demand);

  always @(negedge clk) begin
    if (started) begin
      check("m_phase", 32'(phase), 32'(ms.ph));
      check("m_way", 32'(active_way), 32'(ms.way));
      check("m_light", 32'(light), 32'(exp_light(ms)));
    end
  end

  task automatic do_reset(input logic [NW-1:0] d);
    rst = 1'b1; demand = d; hold = 1'b0; tick_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_way", 32'(active_way), 32'd3);
    check("rst_light", 32'(light), 32'h924);
    rst = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while (32'(phase) != ph && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("wait_timeout", 32'(phase), 32'(ph));
  endtask

  task automatic measure(input int ph, output int len);
    len = 0;
    while (32'(phase) == ph && len < 500) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    int len;
    int rest;
    rst = 1'b1; tick_en = 1'b1; demand = 4'b1111; hold = 1'b0;
    @(negedge clk);
    started = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_rst_phase", 32'(phase), 32'd0);
    check("t1_rst_way", 32'(active_way), 32'd3);
    check("t1_rst_light", 32'(light), 32'h924);
    rst = 1'b0;
    @(negedge clk);
    check("t1_allred_1", 32'(phase), 32'd0);
    @(negedge clk);
    check("t1_green0_light", 32'(light), 32'h922);
    check("t1_green0_way", 32'(active_way), 32'd0);

    // Round robin with everyone waiting
    measure(1, len); check("t2_green_len", len, GD);
    measure(2, len); check("t2_yel_len", len, YD);
    measure(0, len); check("t2_ar_len", len, AD);
    for (int k = 1; k <= 4; k++) begin
      check("t2_rr_way", 32'(active_way), 32'(k % NW));
      measure(1, len); check("t2_green_len", len, GD);
      measure(2, len);
      measure(0, len);
    end

    // Only way 2 waiting
    do_reset(4'b0100);
    wait_phase(1);
    check("t3_way", 32'(active_way), 32'd2);
    check("t3_light", 32'(light), 32'h8A4);
    measure(1, len); measure(2, len); measure(0, len);
    check("t3_again_way", 32'(active_way), 32'd2);
    check("t3_again_ph", 32'(phase), 32'd1);

    // No demand, then way 3 arrives during way-0 green
    do_reset(4'b0000);
    wait_phase(1);
    check("t4_way0", 32'(active_way), 32'd0);
    @(negedge clk);
    demand = 4'b1000;
    measure(1, len); check("t4_green_rest", len, GD - 1);
    measure(2, len); measure(0, len);
    check("t4_skip_way", 32'(active_way), 32'd3);

    // Hold mid-green, then reset mid-yellow
    do_reset(4'b1111);
    wait_phase(1);
    len = 0;
    repeat (5) begin len++; @(negedge clk); end
    hold = 1'b1;
    repeat (10) begin len++; @(negedge clk); end
    hold = 1'b0;
    measure(1, rest);
    check("t5_hold_green_len", len + rest, 30);
    check("t5_in_yellow", 32'(phase), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_phase", 32'(phase), 32'd0);
    check("t5_rst_way", 32'(active_way), 32'd3);
    check("t5_rst_light", 32'(light), 32'h924);
    rst = 1'b0;

    // Sparse ticks, holds and changing demand against the model
    for (int c = 0; c < 1500; c++) begin
      tick_en = ($urandom % 3) != 0;
      hold    = ($urandom % 9) == 0;
      if ($urandom % 20 == 0) demand = 4'($urandom);
      rst     = ($urandom % 400) == 0;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
